loader_packetizer: RTL and testbench

Serializes host-side loader commands into the byte stream that the core's UART loader consumes. Supported commands are PING, IMEM word write, BMEM tile write, and thread UPDATE. It sits between a command source (a test harness, or a host-side FPGA controller) and a UART transmitter. It frames each command exactly as the loader parses it and drives a byte-level valid/ready handshake toward the transmitter.

---
 rtl/loader_packetizer.sv | 99 +++++++++
 tb/tb_loader_packetizer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/loader_packetizer.sv
// loader_packetizer: frames PING/IMEM/BMEM/UPDATE loader commands into a byte stream
module loader_packetizer #(
  parameter int BITWIDTH = 32,
  parameter int MESHUNITS = 2,
  parameter int TILEUNITS = 2,
  localparam int B = BITWIDTH / 8,
  localparam int NWORDS = MESHUNITS * MESHUNITS * TILEUNITS * TILEUNITS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_type,
  input  logic [BITWIDTH-1:0]        cmd_addr,
  input  logic [BITWIDTH-1:0]        cmd_imem_data,
  input  logic [NWORDS*BITWIDTH-1:0] cmd_bmem_data,
  input  logic [3:0]                 cmd_flags,
  output logic [7:0]                 byte_out,
  output logic                       byte_valid,
  input  logic                       byte_ready,
  output logic                       busy,
  output logic                       done
);
  typedef enum logic [1:0] {IDLE, HEADER, ADDR, DATA} state_t;
  localparam logic [15:0] WORD_LAST = 16'(B - 1);
  localparam logic [15:0] BMEM_LAST = 16'(NWORDS * B - 1);
  state_t state_q, state_d;
  logic [15:0] ctr_q, ctr_d;
  logic done_q, done_d;
  logic [1:0] type_q, type_d;
  logic [BITWIDTH-1:0] addr_q, addr_d, imem_q, imem_d;
  logic [NWORDS*BITWIDTH-1:0] bmem_q, bmem_d;
  logic [3:0] flags_q, flags_d;
  logic [15:0] data_last;
  logic xfer;
  assign cmd_ready = state_q == IDLE;
  assign busy = !cmd_ready;
  assign byte_valid = busy;
  assign done = done_q;
  assign xfer = byte_valid && byte_ready;
  assign data_last = type_q == 2'b01 ? WORD_LAST : BMEM_LAST;
  // select the current byte: header, or the counter-indexed byte of the active shadow register
  always_comb begin
    byte_out = state_q == HEADER ? {type_q, 2'b00, type_q == 2'b11 ? flags_q : 4'h0} :
               state_q == ADDR   ? 8'(addr_q >> {ctr_q, 3'b000}) :
               state_q == DATA   ? (type_q == 2'b01 ? 8'(imem_q >> {ctr_q, 3'b000})
                                                    : 8'(bmem_q >> {ctr_q, 3'b000})) : 8'h00;
  end
  // next state: latch command in IDLE, advance one byte per transfer, clear counter on state entry
  always_comb begin
    state_d = state_q;
    ctr_d = ctr_q;
    done_d = 1'b0;
    type_d = type_q;
    addr_d = addr_q;
    imem_d = imem_q;
    bmem_d = bmem_q;
    flags_d = flags_q;
    if (state_q == IDLE) begin
      if (cmd_valid) begin
        type_d = cmd_type;
        addr_d = cmd_addr;
        imem_d = cmd_imem_data;
        bmem_d = cmd_bmem_data;
        flags_d = cmd_flags;
        state_d = HEADER;
        ctr_d = '0;
      end
    end else if (xfer) begin
      case (state_q)
        HEADER:  state_d = (type_q == 2'b00 || type_q == 2'b11) ? IDLE : ADDR;
        ADDR:    state_d = ctr_q == WORD_LAST ? DATA : ADDR;
        default: state_d = ctr_q == data_last ? IDLE : DATA;
      endcase
      ctr_d = state_d == state_q ? ctr_q + 16'd1 : 16'd0;
      done_d = state_d == IDLE;
    end
  end
  // control registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ctr_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q <= ctr_d;
      done_q <= done_d;
    end
  end
  // command shadow registers, only meaningful while a packet is in flight
  always_ff @(posedge clock) begin
    type_q <= type_d;
    addr_q <= addr_d;
    imem_q <= imem_d;
    bmem_q <= bmem_d;
    flags_q <= flags_d;
  end
endmodule

// File: tb/tb_loader_packetizer.sv
// tb_loader_packetizer: table-driven and randomized checks of the loader byte framing
module tb_loader_packetizer;
  localparam int BW = 32, MU = 2, TU = 2, B = BW / 8, NW = MU * MU * TU * TU, DW = NW * BW;
  logic clock = 0, reset = 1, cmd_valid = 0, byte_ready = 0;
  logic cmd_ready, byte_valid, busy, done;
  logic [1:0] cmd_type = 0;
  logic [BW-1:0] cmd_addr = 0, cmd_imem_data = 0;
  logic [DW-1:0] cmd_bmem_data = '0;
  logic [3:0] cmd_flags = 0;
  logic [7:0] byte_out;
  logic [7:0] exp_q[$], got_q[$];
  int total = 0, bad = 0, cyc = 0, hdr_cyc = 0;

  typedef struct {
    logic [1:0] t;
    logic [BW-1:0] a;
    logic [BW-1:0] d;
    bit seq_m;
    logic [3:0] f;
    int rmode;
    bit noisy;
    int len;
    logic [7:0] hdr;
  } vec_t;
  vec_t tbl[6];

  always #5 clock = ~clock;

  loader_packetizer #(.BITWIDTH(BW), .MESHUNITS(MU), .TILEUNITS(TU)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_imem_data(cmd_imem_data),
    .cmd_bmem_data(cmd_bmem_data), .cmd_flags(cmd_flags), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // reference packet: header, then address bytes, then data bytes, all LSB first
  task automatic model(input logic [1:0] t, input logic [BW-1:0] a, input logic [BW-1:0] d,
                       input logic [DW-1:0] m, input logic [3:0] f);
    int n;
    exp_q = {};
    exp_q.push_back(8'(int'(t) * 64 + (t == 2'b11 ? int'(f) : 0)));
    if (t == 2'b01 || t == 2'b10) begin
      for (int i = 0; i < B; i++) exp_q.push_back(8'(a >> (8 * i)));
      n = t == 2'b01 ? B : NW * B;
      for (int i = 0; i < n; i++) exp_q.push_back(t == 2'b01 ? 8'(d >> (8 * i)) : 8'(m >> (8 * i)));
    end
  endtask

  task automatic send(input logic [1:0] t, input logic [BW-1:0] a, input logic [BW-1:0] d,
                      input logic [DW-1:0] m, input logic [3:0] f, input int rmode,
                      input bit noisy, input int abort_at, input string name);
    logic [5:0] pat = 6'b101001;
    logic [7:0] held = 0;
    bit stalled = 0, r;
    int ph = 0;
    model(t, a, d, m, f);
    got_q = {};
    chk({name, "/ready_idle"}, cmd_ready, 1);
    cmd_type = t; cmd_addr = a; cmd_imem_data = d; cmd_bmem_data = m; cmd_flags = f;
    cmd_valid = 1;
    byte_ready = 1'($urandom_range(0, 1));
    tick;
    cmd_valid = 0;
    cmd_type = 2'($urandom); cmd_addr = $urandom; cmd_imem_data = $urandom; cmd_flags = 4'($urandom);
    for (int i = 0; i < NW; i++) cmd_bmem_data[i*BW +: BW] = $urandom;
    chk({name, "/hdr_valid"}, byte_valid, 1);
    chk({name, "/done_low"}, done, 0);
    hdr_cyc = cyc;
    for (int k = 0; k < 2000; k++) begin
      if (stalled) begin
        chk({name, "/stall_hold"}, byte_out, held);
        chk({name, "/stall_valid"}, byte_valid, 1);
      end
      if (!byte_valid) break;
      chk({name, "/busy_ready"}, cmd_ready, 0);
      chk({name, "/busy_done"}, done, 0);
      r = rmode == 0 ? 1'b1 : rmode == 1 ? pat[ph % 6] : 1'($urandom_range(0, 1));
      ph++;
      byte_ready = r;
      cmd_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) cmd_type = 2'($urandom);
      if (r) got_q.push_back(byte_out);
      stalled = !r;
      held = byte_out;
      tick;
      cmd_valid = 0;
      if (abort_at != 0 && got_q.size() == abort_at) begin
        reset = 1;
        tick;
        chk({name, "/rst_valid"}, byte_valid, 0);
        chk({name, "/rst_done"}, done, 0);
        chk({name, "/rst_busy"}, busy, 0);
        chk({name, "/rst_ready"}, cmd_ready, 1);
        reset = 0;
        for (int i = 0; i < abort_at; i++) chk($sformatf("%s/byte%0d", name, i), got_q[i], exp_q[i]);
        return;
      end
      if (got_q.size() == exp_q.size()) break;
    end
    chk({name, "/len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s/byte%0d", name, i), got_q[i], exp_q[i]);
    chk({name, "/end_valid"}, byte_valid, 0);
    chk({name, "/end_done"}, done, 1);
    chk({name, "/end_ready"}, cmd_ready, 1);
    chk({name, "/end_busy"}, busy, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] seq_m;
    int p;
    for (int i = 0; i < NW; i++) seq_m[i*BW +: BW] = BW'(i + 1);
    tbl[0] = '{2'b11, 32'h0, 32'h0, 1'b0, 4'b1011, 0, 1'b0, 1, 8'hCB};
    tbl[1] = '{2'b01, 32'h10, 32'hDEADBEEF, 1'b0, 4'h0, 0, 1'b0, 9, 8'h40};
    tbl[2] = '{2'b10, 32'h100, 32'h0, 1'b1, 4'h0, 0, 1'b1, 69, 8'h80};
    tbl[3] = '{2'b01, 32'h10, 32'hDEADBEEF, 1'b0, 4'h0, 1, 1'b0, 9, 8'h40};
    tbl[4] = '{2'b00, 32'h5, 32'h7, 1'b0, 4'hF, 2, 1'b1, 1, 8'h00};
    tbl[5] = '{2'b11, 32'h0, 32'h0, 1'b0, 4'h0, 1, 1'b0, 1, 8'hC0};

    cmd_valid = 1;
    cmd_type = 2'b01;
    tick;
    tick;
    chk("rst/ready", cmd_ready, 1);
    chk("rst/valid", byte_valid, 0);
    chk("rst/byte", byte_out, 0);
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    cmd_valid = 0;
    reset = 0;
    tick;
    chk("rst/no_accept", byte_valid, 0);

    for (int v = 0; v < 6; v++) begin
      send(tbl[v].t, tbl[v].a, tbl[v].d, tbl[v].seq_m ? seq_m : '0, tbl[v].f, tbl[v].rmode,
           tbl[v].noisy, 0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d/tlen", v), got_q.size(), tbl[v].len);
      if (got_q.size() > 0) chk($sformatf("vec%0d/thdr", v), got_q[0], tbl[v].hdr);
    end

    tick;
    send(2'b10, 32'h100, 32'h0, seq_m, 4'h0, 0, 1'b0, 20, "abort");
    send(2'b00, 32'h0, 32'h0, '0, 4'h0, 0, 1'b0, 0, "ping_after_rst");
    chk("ping_after_rst/tlen", got_q.size(), 1);

    tick;
    send(2'b00, 32'h0, 32'h0, '0, 4'h0, 0, 1'b0, 0, "b2b_ping");
    p = hdr_cyc;
    send(2'b11, 32'h0, 32'h0, '0, 4'h0, 0, 1'b0, 0, "b2b_upd");
    chk("b2b/gap", hdr_cyc - p, 2);
    if (got_q.size() > 0) chk("b2b/upd_hdr", got_q[0], 8'hC0);

    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] m;
      for (int i = 0; i < NW; i++) m[i*BW +: BW] = $urandom;
      if ($urandom_range(0, 3) == 0) tick;
      send(2'($urandom), $urandom, $urandom, m, 4'($urandom), 2, 1'b1, 0, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
